rom_download_ctrl: RTL and testbench
====================================

// Module: rom_download_ctrl
// PURPOSE
//  Sequences HPS ioctl ROM downloads into the BattleZone ROM regions (program, vector, math-box PROM).
//  Shares the single ROM address bus between download writes and core fetches.
//  Holds the game core in reset during a load and for a settle window afterwards.
//  Sits between hps_io and the core top; its cpu_hold output is ORed into the core reset.
// PARAMETERS
//  PROG_SIZE   16'h8000  bytes in program ROM region; region base 0
//  VEC_SIZE    16'h4000  bytes in vector ROM region; base PROG_SIZE
//  MBOX_SIZE   16'h1000  bytes in math-box PROM region; base PROG_SIZE+VEC_SIZE
//  HOLD_CYCLES 16        cycles cpu_hold stays high after a load ends or after reset (>=1)
// PORTS
//  clk_sys        in   1   system clock, all logic on rising edge
//  reset          in   1   synchronous, active-high
//  ioctl_download in   1   high while HPS download active
//  ioctl_wr       in   1   one-cycle strobe: ioctl_addr/ioctl_dout valid
//  ioctl_addr     in   25  download byte address
//  ioctl_dout     in   8   download byte
//  cpu_addr       in   16  core fetch address, passed to rom_addr when bus not owned by loader
//  rom_addr       out  16  region-local ROM address
//  rom_din        out  8   ROM write data
//  rom_we         out  3   one-hot write enable: [0] prog, [1] vec, [2] mbox
//  cpu_hold       out  1   core reset request
//  dl_done        out  1   sticky: a download completed without overflow
//  dl_overflow    out  1   sticky per download: byte received at addr >= total size
//  dl_count       out  17  bytes accepted in current/last download, saturates at 17'h1FFFF
// BEHAVIOUR
//  Reset: state=HOLD, hold counter=HOLD_CYCLES, cpu_hold=1, rom_we=0, rom_din=0,
//   dl_done=0, dl_overflow=0, dl_count=0. Reset mid-load aborts; pending write dropped.
//  FSM: IDLE, LOAD, FLUSH, HOLD.
//   IDLE:  cpu_hold=0, rom_addr=cpu_addr (combinational). ioctl_download=1 -> LOAD.
//   LOAD:  cpu_hold=1; on entry clear dl_count, dl_overflow, dl_done. ioctl_download=0 -> FLUSH.
//   FLUSH: exactly one cycle; retires any write registered in the last LOAD cycle -> HOLD.
//   HOLD:  cpu_hold=1; counter decrements each cycle; at 1 -> IDLE (HOLD_CYCLES cycles total).
//    ioctl_download=1 in HOLD -> LOAD immediately.
//   On exit FLUSH->HOLD, dl_done <= ~dl_overflow.
//  Write pipeline (LOAD, FLUSH): ioctl_wr sampled high at cycle N -> rom_we one-hot,
//   rom_addr, rom_din valid at cycle N+1 for exactly one cycle. Latency 1, no backpressure.
//   Back-to-back strobes every cycle supported.
//  Decode on ioctl_addr (full 25 bits compared):
//   a < PROG_SIZE: we[0], local = a
//   a < PROG_SIZE+VEC_SIZE: we[1], local = a-PROG_SIZE
//   a < PROG_SIZE+VEC_SIZE+MBOX_SIZE: we[2], local = a-PROG_SIZE-VEC_SIZE
//   Otherwise: no we, dl_overflow<=1, byte not counted.
//   local address truncated to 16 bits after subtraction.
//  rom_addr mux: in LOAD, FLUSH and HOLD, rom_addr = registered write address (cpu_addr ignored).
//   In IDLE, rom_addr = cpu_addr.
//  dl_count: increments per accepted (in-range) strobe; saturates.
//  ioctl_wr while not LOAD: ignored.
//  ioctl_wr in same cycle ioctl_download falls: write still committed via FLUSH.
//  rom_we never has more than one bit set; always 0 in IDLE and HOLD.
// TESTING
//  T1: release reset, cpu_addr=16'h1234 -> cpu_hold=1 for 16 cycles, then 0;
//      rom_addr=16'h1234 in IDLE; rom_we=0 throughout.
//  T2: download 0x0000..0x8FFF, one strobe/cycle -> we[0] for the first 32768 bytes, we[1] local 0..0xFFF;
//      dl_count=0x9000; dl_done=1 after FLUSH.
//  T3: single strobe addr 0xC005, data 0xA5 -> next cycle rom_we=3'b100, rom_addr=0x0005, rom_din=0xA5; one cycle only.
//  T4: strobe addr 0xD000 -> rom_we=0, dl_overflow=1, dl_count unchanged, dl_done=0 after load end.
//  T5: ioctl_wr on last cycle of ioctl_download (addr 0x7FFF) -> we[0] pulse in FLUSH; HOLD 16 cycles follows.
//  T6: reset asserted mid-LOAD with strobe pending -> no rom_we next cycle, cpu_hold=1, dl_count=0, HOLD restarts.

Source files
------------

// File: rtl/rom_download_ctrl.sv
// rom_download_ctrl
// Sequences HPS ioctl ROM downloads into the program, vector and math-box
// ROM regions. It shares the single ROM address bus between loader writes and
// core fetches. It holds the game core in reset while a load runs and for a
// short settle window afterwards.
//
// Write handshake: there is no valid/ready pair and no backpressure. An
// ioctl_wr strobe sampled high in LOAD at cycle N shows up as a one-hot rom_we
// pulse, with rom_addr and rom_din, at cycle N+1 for exactly one cycle.
// Strobes outside LOAD are dropped.
module rom_download_ctrl #(
  parameter logic [15:0] PROG_SIZE   = 16'h8000,
  parameter logic [15:0] VEC_SIZE    = 16'h4000,
  parameter logic [15:0] MBOX_SIZE   = 16'h1000,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [15:0] cpu_addr,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_din,
  output logic [2:0]  rom_we,
  output logic        cpu_hold,
  output logic        dl_done,
  output logic        dl_overflow,
  output logic [16:0] dl_count,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // Region bases, widened so the whole 25-bit download address is compared.
  localparam logic [24:0] VEC_BASE  = {9'd0, PROG_SIZE};
  localparam logic [24:0] MBOX_BASE = VEC_BASE + {9'd0, VEC_SIZE};
  localparam logic [24:0] ROM_END   = MBOX_BASE + {9'd0, MBOX_SIZE};
  localparam logic [15:0] HOLD_INIT = 16'(HOLD_CYCLES);

  state_t      state, state_nxt;
  logic [15:0] hold_cnt;
  logic [2:0]  dec_we;
  logic [15:0] dec_off;
  logic        wr_take;
  logic        wr_hit;
  logic [2:0]  we_q;
  logic [15:0] addr_q;
  logic [7:0]  din_q;

  // Region decode of the incoming download address into a one-hot enable and a region-local offset.
  always_comb begin
    dec_we  = 3'b000;
    dec_off = ioctl_addr[15:0];
    if (ioctl_addr < VEC_BASE) begin
      dec_we = 3'b001;
    end else if (ioctl_addr < MBOX_BASE) begin
      dec_we  = 3'b010;
      dec_off = 16'(ioctl_addr - VEC_BASE);
    end else if (ioctl_addr < ROM_END) begin
      dec_we  = 3'b100;
      dec_off = 16'(ioctl_addr - MBOX_BASE);
    end
  end

  assign wr_take = (state == ST_LOAD) && ioctl_wr;
  assign wr_hit  = wr_take && (dec_we != 3'b000);

  // Next-state logic. A new download pre-empts the settle window.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (ioctl_download) state_nxt = ST_LOAD;
      ST_LOAD:  if (!ioctl_download) state_nxt = ST_FLUSH;
      ST_FLUSH: state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (ioctl_download)          state_nxt = ST_LOAD;
        else if (hold_cnt <= 16'd1)  state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_HOLD;
    endcase
  end

  // State register. Reset lands in HOLD so the core stays held after power-up.
  always_ff @(posedge clk_sys) begin
    if (reset) state <= ST_HOLD;
    else       state <= state_nxt;
  end

  // Settle counter. It is reloaded in FLUSH and counts down while in HOLD.
  always_ff @(posedge clk_sys) begin
    if (reset)                  hold_cnt <= HOLD_INIT;
    else if (state == ST_FLUSH) hold_cnt <= HOLD_INIT;
    else if (state == ST_HOLD)  hold_cnt <= hold_cnt - 16'd1;
  end

  // One-stage write pipeline. Reset drops any strobe still in flight.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      we_q   <= 3'b000;
      addr_q <= 16'h0000;
      din_q  <= 8'h00;
    end else begin
      we_q <= wr_hit ? dec_we : 3'b000;
      if (wr_hit) begin
        addr_q <= dec_off;
        din_q  <= ioctl_dout;
      end
    end
  end

  // Download status. Cleared on entry to LOAD; dl_done is settled when FLUSH exits.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_count    <= 17'd0;
      dl_overflow <= 1'b0;
      dl_done     <= 1'b0;
    end else if ((state != ST_LOAD) && (state_nxt == ST_LOAD)) begin
      dl_count    <= 17'd0;
      dl_overflow <= 1'b0;
      dl_done     <= 1'b0;
    end else begin
      if (wr_hit && (dl_count != 17'h1FFFF)) dl_count <= dl_count + 17'd1;
      if (wr_take && (dec_we == 3'b000))     dl_overflow <= 1'b1;
      if (state == ST_FLUSH)                 dl_done <= ~dl_overflow;
    end
  end

  assign rom_we    = we_q;
  assign rom_din   = din_q;
  assign rom_addr  = (state == ST_IDLE) ? cpu_addr : addr_q;
  assign cpu_hold  = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_rom_download_ctrl.sv
// tb_rom_download_ctrl
// Directed bench for rom_download_ctrl. Driver tasks push the expected ROM
// writes into exp_q. A negedge monitor pops and compares every rom_we pulse.
module tb_rom_download_ctrl;

  logic        clk_sys;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [15:0] cpu_addr;
  logic [15:0] rom_addr;
  logic [7:0]  rom_din;
  logic [2:0]  rom_we;
  logic        cpu_hold;
  logic        dl_done;
  logic        dl_overflow;
  logic [16:0] dl_count;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [26:0] exp_q[$];

  rom_download_ctrl dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .cpu_addr       (cpu_addr),
    .rom_addr       (rom_addr),
    .rom_din        (rom_din),
    .rom_we         (rom_we),
    .cpu_hold       (cpu_hold),
    .dl_done        (dl_done),
    .dl_overflow    (dl_overflow),
    .dl_count       (dl_count),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit expired checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  function automatic logic [26:0] pk(input logic [2:0] we, input logic [15:0] a, input logic [7:0] d);
    return {we, a, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // driver: one strobe, expected write pushed when exp_we is nonzero
  task automatic wr(input logic [24:0] a, input logic [7:0] d,
                    input logic [2:0] exp_we, input logic [15:0] exp_addr);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    if (exp_we != 3'b000) exp_q.push_back(pk(exp_we, exp_addr, d));
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic start_load();
    ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
  endtask

  // drop download, step through FLUSH into HOLD
  task automatic end_load();
    ioctl_download = 1'b0;
    @(posedge clk_sys); #1;
    @(posedge clk_sys); #1;
  endtask

  // n negedges with cpu_hold high, then one with it low
  task automatic check_hold(input int n, input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys);
      if (cpu_hold !== 1'b1) bad++;
    end
    chk({name, "_hold_high"}, bad, 0);
    @(negedge clk_sys);
    chk({name, "_hold_released"}, cpu_hold, 1'b0);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (cpu_hold !== 1'b0 && n < 40) begin
      @(negedge clk_sys);
      n++;
    end
    chk({name, "_reach_idle"}, cpu_hold, 1'b0);
  endtask

  // scoreboard monitor
  always @(negedge clk_sys) begin
    logic [26:0] e;
    if (rom_we !== 3'b000) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got=%h exp=none", {rom_we, rom_addr, rom_din});
      end else begin
        e = exp_q.pop_front();
        if ({rom_we, rom_addr, rom_din} !== e) begin
          failures++;
          $display("FAIL rom_write got=%h exp=%h", {rom_we, rom_addr, rom_din}, e);
        end
      end
    end
  end

  initial begin
    logic [24:0] a;
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = 25'd0;
    ioctl_dout     = 8'd0;
    cpu_addr       = 16'h1234;
    repeat (3) @(posedge clk_sys);
    #1;

    // T1: reset state, 16-cycle hold, then cpu_addr passthrough
    chk("reset_cpu_hold", cpu_hold, 1'b1);
    chk("reset_rom_we", rom_we, 3'b000);
    chk("reset_rom_din", rom_din, 8'h00);
    chk("reset_dl_count", dl_count, 17'd0);
    chk("reset_flags", {dl_done, dl_overflow}, 2'b00);
    reset = 1'b0;
    check_hold(16, "t1");
    chk("t1_idle_rom_addr", rom_addr, 16'h1234);
    cpu_addr = 16'hBEEF;
    #1;
    chk("t1_idle_rom_addr_comb", rom_addr, 16'hBEEF);

    // T2: 0x0000..0x8FFF back to back across the prog/vec boundary
    start_load();
    for (int i = 0; i < 'h9000; i++) begin
      a = 25'(i);
      if (i < 'h8000) wr(a, a[7:0] ^ 8'h5C, 3'b001, a[15:0]);
      else            wr(a, a[7:0] ^ 8'h5C, 3'b010, a[15:0] - 16'h8000);
    end
    end_load();
    chk("t2_dl_count", dl_count, 17'h09000);
    chk("t2_dl_done", dl_done, 1'b1);
    chk("t2_dl_overflow", dl_overflow, 1'b0);
    wait_idle("t2");

    // T3: single mbox strobe, status cleared on load entry
    start_load();
    chk("t3_entry_dl_count", dl_count, 17'd0);
    chk("t3_entry_dl_done", dl_done, 1'b0);
    chk("t3_load_cpu_hold", cpu_hold, 1'b1);
    wr(25'h000C005, 8'hA5, 3'b100, 16'h0005);
    @(negedge clk_sys);
    @(negedge clk_sys);
    chk("t3_pulse_one_cycle", rom_we, 3'b000);
    end_load();
    chk("t3_dl_count", dl_count, 17'd1);
    chk("t3_dl_done", dl_done, 1'b1);
    wait_idle("t3");

    // T4: top of mbox, then overflow (including a high-bit address)
    start_load();
    wr(25'h0000010, 8'h3C, 3'b001, 16'h0010);
    wr(25'h000CFFF, 8'hC3, 3'b100, 16'h0FFF);
    wr(25'h000D000, 8'h77, 3'b000, 16'h0000);
    chk("t4_overflow_set", dl_overflow, 1'b1);
    chk("t4_count_after_ovf", dl_count, 17'd2);
    wr(25'h1000005, 8'h66, 3'b000, 16'h0000);
    chk("t4_count_high_addr", dl_count, 17'd2);
    end_load();
    chk("t4_dl_done", dl_done, 1'b0);
    chk("t4_dl_overflow_sticky", dl_overflow, 1'b1);
    wait_idle("t4");

    // T5: strobe on the falling download cycle is committed in FLUSH
    start_load();
    ioctl_wr       = 1'b1;
    ioctl_addr     = 25'h0007FFF;
    ioctl_dout     = 8'h5A;
    ioctl_download = 1'b0;
    exp_q.push_back(pk(3'b001, 16'h7FFF, 8'h5A));
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    chk("t5_flush_cpu_hold", cpu_hold, 1'b1);
    @(posedge clk_sys); #1;
    chk("t5_dl_count", dl_count, 17'd1);
    chk("t5_dl_done", dl_done, 1'b1);
    check_hold(16, "t5");

    // T6: reset mid-load with a strobe pending
    start_load();
    wr(25'h0000100, 8'h11, 3'b001, 16'h0100);
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h0000200;
    ioctl_dout = 8'h22;
    reset      = 1'b1;
    @(posedge clk_sys); #1;
    reset          = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    chk("t6_no_we", rom_we, 3'b000);
    chk("t6_cpu_hold", cpu_hold, 1'b1);
    chk("t6_dl_count", dl_count, 17'd0);
    check_hold(15, "t6");

    repeat (2) @(negedge clk_sys);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
